// File: rtl/lpc_host_pkg.sv
// lpc_host_pkg -- shared definitions for the LPC I/O host.
//   * lpc_state_e : host FSM state encoding (ST_ABORT exists only when
//                   LPC_HOST_ABORT_EN is defined)
//   * LAD nibble constants for START / CYCTYP phases
//   * SYNC codes returned by the peripheral
//   * addr_nibble(): selects the address nibble driven in ADDR clock idx
package lpc_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_CYCTYP = 4'd2,
    ST_ADDR   = 4'd3,
    ST_WDATA  = 4'd4,
    ST_HTAR1  = 4'd5,
    ST_HTAR2  = 4'd6,
    ST_SYNC   = 4'd7,
    ST_RDATA  = 4'd8,
    ST_PTAR1  = 4'd9,
    ST_PTAR2  = 4'd10,
`ifdef LPC_HOST_ABORT_EN
    ST_ABORT  = 4'd11,
`endif
    ST_DONE   = 4'd12
  } lpc_state_e;

  localparam logic [3:0] LAD_START  = 4'h0;
  localparam logic [3:0] CYC_IO_RD  = 4'h0;
  localparam logic [3:0] CYC_IO_WR  = 4'h2;
  localparam logic [3:0] LAD_IDLE   = 4'hF;

  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_SWAIT = 4'h5;
  localparam logic [3:0] SYNC_LWAIT = 4'h6;
  localparam logic [3:0] SYNC_ERROR = 4'hA;

  // Address goes out MSB nibble first: idx 0 -> [15:12], idx 3 -> [3:0].
  function automatic logic [3:0] addr_nibble(input logic [15:0] addr,
                                             input logic [1:0]  idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = addr[15:12];
      2'd1:    nib = addr[11:8];
      2'd2:    nib = addr[7:4];
      default: nib = addr[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/lpc_host_sync_timer.sv
// lpc_host_sync_timer -- counts SYNC wait clocks and flags the timeout.
//   clk_i, rst_ni : LPC clock, async active-low reset
//   clear_i       : hold counter at zero (host not in SYNC)
//   wait_i        : current SYNC clock carries a wait (non-ready) code
//   expired_o     : this wait clock is the SYNC_TIMEOUT-th one
module lpc_host_sync_timer #(
  parameter int unsigned SYNC_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic wait_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(SYNC_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // cnt_q holds the number of wait clocks already seen, so the current wait
  // clock reaches the limit when cnt_q is one below it.
  assign expired_o = wait_i && (cnt_q == CW'(SYNC_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wait_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lpc_host.sv
// lpc_host -- LPC I/O read/write host (single outstanding cycle).
// Optional feature: define LPC_HOST_ABORT_EN to drive an LFRAME# abort
// sequence on SYNC timeout; otherwise a timeout completes directly.
//   lpc_clk_i, pci_reset_ni          : clock, async active-low reset
//   req_i, req_wr_i, req_addr_i,
//   req_data_i                       : request (sampled only while not busy)
//   busy_o, done_o, rd_data_o,
//   err_o, timeout_o                 : status / completion
//   lpc_frame_o, lpc_bus_out_o,
//   lpc_bus_oe_o, lpc_bus_in_i       : LPC pins (LAD tristate at top level)
//   state_o                          : current FSM state (debug)
// Handshake: a request is taken on any clock edge where req_i=1 and
// busy_o=0 (IDLE or DONE); completion is the one-clock done_o pulse, with
// rd_data_o/err_o/timeout_o valid then and held until the next accept.
module lpc_host
  import lpc_host_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 64
) (
  input  logic        lpc_clk_i,
  input  logic        pci_reset_ni,
  input  logic        req_i,
  input  logic        req_wr_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  rd_data_o,
  output logic        err_o,
  output logic        timeout_o,
  output logic        lpc_frame_o,
  output logic [3:0]  lpc_bus_out_o,
  output logic        lpc_bus_oe_o,
  input  logic [3:0]  lpc_bus_in_i,
  output logic [3:0]  state_o
);

  lpc_state_e  state_q;
  logic [1:0]  nib_q;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rd_data_q;
  logic        err_q;
  logic        timeout_q;
  logic        busy_q;
  logic        done_q;
  logic        frame_q;
  logic [3:0]  lad_q;
  logic        oe_q;
`ifdef LPC_HOST_ABORT_EN
  logic [2:0]  abort_cnt_q;
`endif

  logic sync_ready;
  logic sync_wait;
  logic sync_expired;

  assign sync_ready = (lpc_bus_in_i == SYNC_READY) || (lpc_bus_in_i == SYNC_ERROR);
  // Any code other than ready/error (SWAIT, LWAIT or garbage) is a wait.
  assign sync_wait  = (state_q == ST_SYNC) && !sync_ready;

  lpc_host_sync_timer #(
    .SYNC_TIMEOUT(SYNC_TIMEOUT)
  ) u_sync_timer (
    .clk_i    (lpc_clk_i),
    .rst_ni   (pci_reset_ni),
    .clear_i  (state_q != ST_SYNC),
    .wait_i   (sync_wait),
    .expired_o(sync_expired)
  );

  // Outputs are registered: each transition loads the pin values for the
  // state being entered.
  always_ff @(posedge lpc_clk_i or negedge pci_reset_ni) begin
    if (!pci_reset_ni) begin
      state_q     <= ST_IDLE;
      nib_q       <= 2'd0;
      wr_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      rd_data_q   <= 8'h00;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_q     <= 1'b1;
      lad_q       <= LAD_IDLE;
      oe_q        <= 1'b0;
`ifdef LPC_HOST_ABORT_EN
      abort_cnt_q <= 3'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (req_i) begin
            wr_q      <= req_wr_i;
            addr_q    <= req_addr_i;
            wdata_q   <= req_data_i;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            frame_q   <= 1'b0;
            lad_q     <= LAD_START;
            oe_q      <= 1'b1;
            state_q   <= ST_START;
          end else begin
            busy_q  <= 1'b0;
            frame_q <= 1'b1;
            lad_q   <= LAD_IDLE;
            oe_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_START: begin
          frame_q <= 1'b1;
          lad_q   <= wr_q ? CYC_IO_WR : CYC_IO_RD;
          state_q <= ST_CYCTYP;
        end
        ST_CYCTYP: begin
          nib_q   <= 2'd0;
          lad_q   <= addr_nibble(addr_q, 2'd0);
          state_q <= ST_ADDR;
        end
        ST_ADDR: begin
          if (nib_q == 2'd3) begin
            nib_q <= 2'd0;
            if (wr_q) begin
              lad_q   <= wdata_q[3:0];
              state_q <= ST_WDATA;
            end else begin
              lad_q   <= LAD_IDLE;
              state_q <= ST_HTAR1;
            end
          end else begin
            nib_q <= nib_q + 2'd1;
            lad_q <= addr_nibble(addr_q, nib_q + 2'd1);
          end
        end
        ST_WDATA: begin
          if (nib_q == 2'd0) begin
            nib_q <= 2'd1;
            lad_q <= wdata_q[7:4];
          end else begin
            nib_q   <= 2'd0;
            lad_q   <= LAD_IDLE;
            state_q <= ST_HTAR1;
          end
        end
        ST_HTAR1: begin
          oe_q    <= 1'b0;
          state_q <= ST_HTAR2;
        end
        ST_HTAR2: begin
          state_q <= ST_SYNC;
        end
        ST_SYNC: begin
          if (sync_ready) begin
            if (lpc_bus_in_i == SYNC_ERROR) begin
              err_q <= 1'b1;
            end
            nib_q   <= 2'd0;
            state_q <= wr_q ? ST_PTAR1 : ST_RDATA;
          end else if (sync_expired) begin
            timeout_q <= 1'b1;
`ifdef LPC_HOST_ABORT_EN
            frame_q     <= 1'b0;
            lad_q       <= LAD_IDLE;
            oe_q        <= 1'b1;
            abort_cnt_q <= 3'd0;
            state_q     <= ST_ABORT;
`else
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
`endif
          end
        end
        ST_RDATA: begin
          if (nib_q == 2'd0) begin
            rd_data_q[3:0] <= lpc_bus_in_i;
            nib_q          <= 2'd1;
          end else begin
            rd_data_q[7:4] <= lpc_bus_in_i;
            nib_q          <= 2'd0;
            state_q        <= ST_PTAR1;
          end
        end
        ST_PTAR1: begin
          state_q <= ST_PTAR2;
        end
        ST_PTAR2: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
`ifdef LPC_HOST_ABORT_EN
        // Clocks 0..3 hold LFRAME# low with LAD=F; clock 4 releases the bus.
        ST_ABORT: begin
          if (abort_cnt_q == 3'd3) begin
            frame_q     <= 1'b1;
            oe_q        <= 1'b0;
            abort_cnt_q <= 3'd4;
          end else if (abort_cnt_q == 3'd4) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            abort_cnt_q <= abort_cnt_q + 3'd1;
          end
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          frame_q <= 1'b1;
          lad_q   <= LAD_IDLE;
          oe_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign rd_data_o     = rd_data_q;
  assign err_o         = err_q;
  assign timeout_o     = timeout_q;
  assign lpc_frame_o   = frame_q;
  assign lpc_bus_out_o = lad_q;
  assign lpc_bus_oe_o  = oe_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host -- directed self-checking bench for lpc_host.
// Clock k of a cycle is the period after the k-th rising edge following the
// accepting edge; outputs are sampled and inputs changed on falling edges.
module tb_lpc_host;

  localparam int NCLK = 90;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  logic        busy;
  logic        done;
  logic [7:0]  rd_data;
  logic        err;
  logic        timeout;
  logic        frame;
  logic [3:0]  lad_out;
  logic        lad_oe;
  logic [3:0]  lad_in;
  logic [3:0]  state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] lad_log   [0:NCLK];
  logic       frame_log [0:NCLK];
  logic       oe_log    [0:NCLK];
  logic       busy_log  [0:NCLK];
  logic       done_log  [0:NCLK];
  logic       err_log   [0:NCLK];
  logic       tmo_log   [0:NCLK];
  logic [7:0] rd_log    [0:NCLK];
  int         done_clk;
  int         done_cnt;

  lpc_host #(.SYNC_TIMEOUT(64)) dut (
    .lpc_clk_i    (clk),
    .pci_reset_ni (rst_n),
    .req_i        (req),
    .req_wr_i     (req_wr),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .busy_o       (busy),
    .done_o       (done),
    .rd_data_o    (rd_data),
    .err_o        (err),
    .timeout_o    (timeout),
    .lpc_frame_o  (frame),
    .lpc_bus_out_o(lad_out),
    .lpc_bus_oe_o (lad_oe),
    .lpc_bus_in_i (lad_in),
    .state_o      (state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver plus peripheral model: issues one request, answers SYNC with sq
  // starting at the first SYNC clock, then returns rdv nibbles for reads,
  // and LAD=F otherwise. Logs NCLK clocks; spam re-pulses req while busy.
  task automatic run_cycle(input logic wr, input logic [15:0] addr,
                           input logic [7:0] data, input logic [3:0] sq[$],
                           input logic [7:0] rdv, input logic spam);
    int sync_start;
    int idx;
    sync_start = wr ? 11 : 9;
    done_clk   = -1;
    done_cnt   = 0;
    @(negedge clk);
    req      = 1'b1;
    req_wr   = wr;
    req_addr = addr;
    req_data = data;
    lad_in   = 4'hF;
    for (int k = 1; k <= NCLK; k++) begin
      @(negedge clk);
      lad_log[k]   = lad_out;
      frame_log[k] = frame;
      oe_log[k]    = lad_oe;
      busy_log[k]  = busy;
      done_log[k]  = done;
      err_log[k]   = err;
      tmo_log[k]   = timeout;
      rd_log[k]    = rd_data;
      if (done) begin
        done_cnt++;
        if (done_clk < 0) done_clk = k;
      end
      req = spam && (k >= 3) && (k <= 5);
      req_addr = 16'hFFFF;
      req_data = 8'hEE;
      idx = k - sync_start;
      if (idx >= 0 && idx < sq.size()) lad_in = sq[idx];
      else if (!wr && idx == sq.size()) lad_in = rdv[3:0];
      else if (!wr && idx == sq.size() + 1) lad_in = rdv[7:4];
      else lad_in = 4'hF;
    end
  endtask

  initial begin
    logic [3:0] exp_lad [1:9];
    logic [3:0] sq[$];
    logic       no_done;

    rst_n    = 1'b0;
    req      = 1'b0;
    req_wr   = 1'b0;
    req_addr = 16'h0000;
    req_data = 8'h00;
    lad_in   = 4'hF;
    #12;
    chk("rst_frame", frame, 1'b1);
    chk("rst_lad", lad_out, 4'hF);
    chk("rst_oe", lad_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd", rd_data, 8'h00);
    chk("rst_err_tmo", {err, timeout}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x0080 <- 0x5A, immediate ready
    sq = '{4'h0};
    run_cycle(1'b1, 16'h0080, 8'h5A, sq, 8'h00, 1'b0);
    exp_lad = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'hA, 4'h5, 4'hF};
    for (int k = 1; k <= 9; k++) chk($sformatf("wr_lad_c%0d", k), lad_log[k], exp_lad[k]);
    chk("wr_frame_c1", frame_log[1], 1'b0);
    chk("wr_frame_c2", frame_log[2], 1'b1);
    chk("wr_busy_c1", busy_log[1], 1'b1);
    chk("wr_oe_c9", oe_log[9], 1'b1);
    chk("wr_oe_c10", oe_log[10], 1'b0);
    chk("wr_done_clk", done_clk, 14);
    chk("wr_busy_done", busy_log[14], 1'b0);
    chk("wr_err", err_log[14], 1'b0);

    // Read 0x0701, SYNC 5,5,0, data 3,C
    sq = '{4'h5, 4'h5, 4'h0};
    run_cycle(1'b0, 16'h0701, 8'h00, sq, 8'hC3, 1'b0);
    chk("rd_cyctyp", lad_log[2], 4'h0);
    chk("rd_addr_c4", lad_log[4], 4'h7);
    chk("rd_addr_c6", lad_log[6], 4'h1);
    chk("rd_htar1", lad_log[7], 4'hF);
    chk("rd_oe_c8", oe_log[8], 1'b0);
    chk("rd_done_clk", done_clk, 16);
    chk("rd_data", rd_log[16], 8'hC3);
    chk("rd_err_tmo", {err_log[16], tmo_log[16]}, 2'b00);
    chk("rd_data_hold", rd_data, 8'hC3);

    // Write with error SYNC, then clear on next accept
    sq = '{4'hA};
    run_cycle(1'b1, 16'h1234, 8'h00, sq, 8'h00, 1'b0);
    chk("er_done_clk", done_clk, 14);
    chk("er_err", err_log[14], 1'b1);
    chk("er_err_hold", err, 1'b1);
    sq = '{4'h0};
    run_cycle(1'b1, 16'h0010, 8'h01, sq, 8'h00, 1'b0);
    chk("er_cleared_c1", err_log[1], 1'b0);
    chk("er_next_done", done_clk, 14);

    // Read timeout: LAD held at F
    sq = '{};
    run_cycle(1'b0, 16'h0060, 8'h00, sq, 8'hFF, 1'b0);
    chk("to_busy_c72", busy_log[72], 1'b1);
    chk("to_tmo_c72", tmo_log[72], 1'b0);
`ifdef LPC_HOST_ABORT_EN
    chk("to_abort_frame_c73", frame_log[73], 1'b0);
    chk("to_abort_lad_c73", lad_log[73], 4'hF);
    chk("to_abort_oe_c73", oe_log[73], 1'b1);
    chk("to_abort_frame_c76", frame_log[76], 1'b0);
    chk("to_rel_frame_oe_c77", {frame_log[77], oe_log[77]}, 2'b10);
    chk("to_done_clk", done_clk, 78);
    chk("to_tmo", tmo_log[78], 1'b1);
`else
    chk("to_frame_oe_c73", {frame_log[73], oe_log[73]}, 2'b10);
    chk("to_done_clk", done_clk, 73);
    chk("to_tmo", tmo_log[73], 1'b1);
`endif
    chk("to_done_cnt", done_cnt, 1);

    // Req pulsed while busy is ignored
    sq = '{4'h0};
    run_cycle(1'b1, 16'h0200, 8'h33, sq, 8'h00, 1'b1);
    chk("spam_done_clk", done_clk, 14);
    chk("spam_done_cnt", done_cnt, 1);
    chk("spam_tmo_clr", tmo_log[14], 1'b0);
    chk("spam_lad_addr", lad_log[4], 4'h2);

    // Reset during ADDR clock 2
    @(negedge clk);
    req      = 1'b1;
    req_wr   = 1'b1;
    req_addr = 16'h1234;
    req_data = 8'h77;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req = 1'b0;
    end
    chk("mid_addr_c4", lad_out, 4'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_frame_lad_oe", {frame, lad_out, lad_oe}, {1'b1, 4'hF, 1'b0});
    chk("mid_rst_busy_done", {busy, done}, 2'b00);
    chk("mid_rst_rd", rd_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_done = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    chk("mid_no_done", no_done, 1'b1);
    sq = '{4'h0};
    run_cycle(1'b1, 16'h0080, 8'h5A, sq, 8'h00, 1'b0);
    chk("post_rst_frame_c1", {frame_log[1], lad_log[1]}, {1'b0, 4'h0});
    chk("post_rst_done_clk", done_clk, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lpc_host.md
LPC_HOST -- requirements
Module: LpcHost

Interface
REQ-001 Parameter SYNC_TIMEOUT, default 64: maximum SYNC-phase clocks without a ready or error code before the cycle is declared timed out (legal range 2..255).
REQ-002 LpcClock  in  1  33 MHz LPC clock; the only clock.
REQ-003 PciReset  in  1  asynchronous, active-low reset.
REQ-004 Req  in  1  request strobe; sampled only while Busy=0.
REQ-005 ReqWr  in  1  1 = I/O write, 0 = I/O read.
REQ-006 ReqAddr  in  16  I/O address.
REQ-007 ReqData  in  8  write data.
REQ-008 Busy  out  1  cycle in progress.
REQ-009 Done  out  1  one-clock completion pulse.
REQ-010 RdData  out  8  read data, valid with Done.
REQ-011 Err  out  1  peripheral returned error SYNC; valid with Done.
REQ-012 Timeout  out  1  SYNC timeout; valid with Done.
REQ-013 LpcFrame  out  1  LFRAME#, active low.
REQ-014 LpcBusOut  out  4  LAD drive value.
REQ-015 LpcBusOe  out  1  LAD output enable; tristating is done at the top level.
REQ-016 LpcBusIn  in  4  LAD sampled value.

Function
REQ-017 Accept: Req=1 with Busy=0 latches ReqWr/ReqAddr/ReqData; Busy=1 from the next clock; Req while Busy=1 is ignored.
REQ-018 States: IDLE, START, CYCTYP, ADDR (4 clocks), WDATA (2, write only), HTAR1, HTAR2, SYNC, RDATA (2, read only), PTAR1, PTAR2, ABORT, DONE.
REQ-019 START (clock 1 after accept): LpcFrame=0, LpcBusOut=4'h0, Oe=1; LpcFrame=1 in every other state except ABORT.
REQ-020 CYCTYP: LpcBusOut=4'h2 for a write, 4'h0 for a read.
REQ-021 ADDR: ReqAddr nibbles are driven MSB first ([15:12] ... [3:0]); WDATA drives ReqData[3:0], then [7:4].
REQ-022 HTAR1: LpcBusOut=4'hF, Oe=1; Oe=0 from HTAR2 through PTAR2.
REQ-023 SYNC decode: 4'h0 = ready; 4'hA = ready and set Err; 4'h5 or 4'h6 = wait; any other value also counts as wait.
REQ-024 Ready/error leads to RDATA for a read, or PTAR1 for a write. RDATA captures LpcBusIn as RdData[3:0], then [7:4].
REQ-025 Timing with zero wait states: both reads and writes return to IDLE with Done=1 on clock 14 after accept. Each wait clock adds one clock.
REQ-026 Timeout counter: cleared on SYNC entry; increments on each wait clock; on reaching SYNC_TIMEOUT, Timeout=1 and the FSM goes to ABORT (macro set) or DONE (macro clear). Counter width is $clog2(SYNC_TIMEOUT+1).
REQ-027 DONE state: Done=1 and Busy=0 for one clock; Req may be accepted in that same clock.
REQ-028 Err, Timeout and RdData hold their values until the next accept, which clears Err and Timeout.

Reset
REQ-029 While PciReset=0, the module SHALL immediately force:
  - IDLE state
  - LpcFrame=1, LpcBusOut=4'hF, LpcBusOe=0
  - Busy=0, Done=0, RdData=8'h00, Err=0, Timeout=0
REQ-030 A reset asserted mid-cycle abandons the cycle silently (no Done pulse); the first Req after release starts a fresh cycle.

Configuration
REQ-031 Macro LPC_HOST_ABORT_EN defined: on timeout, the module SHALL:
  - drive LpcFrame=0, LpcBusOut=4'hF, Oe=1 for 4 clocks
  - then LpcFrame=1, Oe=0 for 1 clock
  - then enter DONE
REQ-032 Macro LPC_HOST_ABORT_EN undefined: the ABORT state is not compiled in; timeout goes directly to DONE with Oe=0.

Structure
REQ-033 Shared package LpcPkg SHALL hold:
  - the state enum
  - START/CYCTYP nibble constants
  - SYNC codes (READY=4'h0, SWAIT=4'h5, LWAIT=4'h6, ERROR=4'hA)
REQ-034 One sub-module, LpcHostSyncTimer (SYNC wait counter plus timeout compare); all other logic stays in LpcHost.

Verification
REQ-035 Write 0x0080 data 0x5A, immediate SYNC 0 -> LAD sequence 0,2,0,0,8,0,A,5,F; Oe low from clock 10; Done on clock 14; Err=0.
REQ-036 Read 0x0701, SYNC 5,5,0, data nibbles 3,C -> RdData=0xC3; Done on clock 16; Err=0; Timeout=0.
REQ-037 Write with SYNC 4'hA -> Done on clock 14; Err=1; next accept clears Err.
REQ-038 Read with LpcBusIn held 4'hF -> Timeout=1 after 64 SYNC clocks.
  - Macro set: 4-clock abort (LpcFrame low, LAD=F), then Done.
  - Macro clear: Done immediately.
REQ-039 Assert PciReset during ADDR clock 2 -> outputs reach reset values in the same clock; no Done; Req after release -> START on the next clock.
REQ-040 Req pulsed while Busy=1 -> ignored; exactly one Done is produced.
